cordic_iterative_core: RTL and testbench

Iterative, one-iteration-per-cycle CORDIC engine that implements the controller side of BusInterface. It consumes operands and the control word from the bus-side register block, and addresses the arctangent LUT (lutAddress out, combinational angle in). It returns x/y/z results, status bits and an interrupt to the bus side. It supports rotation and vectoring modes with a run-time iteration count.

---
 rtl/cordic_iterative_core.sv | 214 +++++++++++++++++++++
 tb/tb_cordic_iterative_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iterative_core.sv
// cordic_iterative_core: iterative CORDIC engine, one micro-rotation per cycle.
// Rotation (MODE=0) drives z toward 0; vectoring (MODE=1) drives y toward 0.
// The arctangent LUT sits outside: lutAddress out, angle back combinationally.
// Optional build macro CORDIC_GAIN_COMP_EN adds a SCALE state that multiplies
// x/y by p_GAIN (K ~ 0.607253) before the results are published.
module cordic_iterative_core #(
    parameter int                 p_WIDTH      = 32,
    parameter int                 p_LOG2_WIDTH = $clog2(p_WIDTH),
    parameter logic [p_WIDTH-1:0] p_GAIN       = 32'h4DBA76D4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [p_WIDTH-1:0]      xInput,
    input  logic [p_WIDTH-1:0]      yInput,
    input  logic [p_WIDTH-1:0]      zInput,
    input  logic [p_WIDTH-1:0]      controlRegisterInput,
    input  logic [p_WIDTH-1:0]      angle,
    output logic [p_LOG2_WIDTH-1:0] lutAddress,
    output logic [p_WIDTH-1:0]      xResult,
    output logic [p_WIDTH-1:0]      yResult,
    output logic [p_WIDTH-1:0]      zResult,
    output logic [p_WIDTH-1:0]      controlRegisterOutput,
    output logic [p_WIDTH-1:0]      controlRegisterMask,
    output logic                    interrupt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ITERATE = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] S_SCALE   = 2'd3;
`endif

    // Iteration count needs one extra bit: ITER=0 encodes a full p_WIDTH run.
    localparam logic [p_LOG2_WIDTH:0] FULL_N = (p_LOG2_WIDTH+1)'(p_WIDTH);

    logic [1:0]                state_q, state_d;
    logic signed [p_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [p_LOG2_WIDTH-1:0]   i_q, i_d;
    logic [p_LOG2_WIDTH:0]     n_q, n_d;
    logic                      mode_q, mode_d, int_en_q, int_en_d;
    logic                      busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [p_WIDTH-1:0]        xres_q, xres_d, yres_q, yres_d, zres_q, zres_d;
    logic                      irq_q, irq_d;

    logic signed [p_WIDTH-1:0] xs, ys, z_next;
    logic [p_WIDTH:0]          x_ext, y_ext;
    logic                      d_pos, step_ovf, last_iter;
    logic [p_LOG2_WIDTH-1:0]   iter_f;
    logic                      start;

    assign start  = controlRegisterInput[0];
    assign iter_f = controlRegisterInput[8 +: p_LOG2_WIDTH];

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [2*p_WIDTH-1:0] x_prod, y_prod;
    // Full-width signed products; keeping bits [2W-2:W-1] is the >>> (W-1).
    always_comb begin
        x_prod = x_q * $signed(p_GAIN);
        y_prod = y_q * $signed(p_GAIN);
    end
    logic unused_prod;
    assign unused_prod = ^{x_prod[2*p_WIDTH-1], x_prod[p_WIDTH-2:0],
                           y_prod[2*p_WIDTH-1], y_prod[p_WIDTH-2:0]};
`else
    logic unused_gain;
    assign unused_gain = ^p_GAIN;
`endif

    logic unused_ctrl;
    assign unused_ctrl = ^{controlRegisterInput[p_WIDTH-1:8+p_LOG2_WIDTH],
                           controlRegisterInput[7:3]};

    // One micro-rotation datapath; add/sub done one bit wider to catch wrap.
    always_comb begin
        xs     = x_q >>> i_q;
        ys     = y_q >>> i_q;
        d_pos  = mode_q ? y_q[p_WIDTH-1] : ~z_q[p_WIDTH-1];
        if (d_pos) begin
            x_ext  = {x_q[p_WIDTH-1], x_q} - {ys[p_WIDTH-1], ys};
            y_ext  = {y_q[p_WIDTH-1], y_q} + {xs[p_WIDTH-1], xs};
            z_next = z_q - $signed(angle);
        end else begin
            x_ext  = {x_q[p_WIDTH-1], x_q} + {ys[p_WIDTH-1], ys};
            y_ext  = {y_q[p_WIDTH-1], y_q} - {xs[p_WIDTH-1], xs};
            z_next = z_q + $signed(angle);
        end
        step_ovf  = (x_ext[p_WIDTH] ^ x_ext[p_WIDTH-1]) |
                    (y_ext[p_WIDTH] ^ y_ext[p_WIDTH-1]);
        last_iter = ({1'b0, i_q} == (n_q - 1'b1));
    end

    // Controller: IDLE -> ITERATE (N cycles) -> [SCALE] -> FINISH -> IDLE.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        i_d      = i_q;
        n_d      = n_q;
        mode_d   = mode_q;
        int_en_d = int_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        xres_d   = xres_q;
        yres_d   = yres_q;
        zres_d   = zres_q;
        irq_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d      = xInput;
                    y_d      = yInput;
                    z_d      = zInput;
                    mode_d   = controlRegisterInput[1];
                    int_en_d = controlRegisterInput[2];
                    n_d      = (iter_f == '0) ? FULL_N : {1'b0, iter_f};
                    i_d      = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_ITERATE;
                end
            end
            S_ITERATE: begin
                x_d = x_ext[p_WIDTH-1:0];
                y_d = y_ext[p_WIDTH-1:0];
                z_d = z_next;
                if (step_ovf) ovf_d = 1'b1;
                // i stays on N-1 after the last step so lutAddress holds.
                if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_SCALE: begin
                x_d     = x_prod[2*p_WIDTH-2:p_WIDTH-1];
                y_d     = y_prod[2*p_WIDTH-2:p_WIDTH-1];
                state_d = S_FINISH;
            end
`endif
            S_FINISH: begin
                xres_d  = x_q;
                yres_d  = y_q;
                zres_d  = z_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                irq_d   = int_en_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            i_q      <= '0;
            n_q      <= '0;
            mode_q   <= 1'b0;
            int_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            xres_q   <= '0;
            yres_q   <= '0;
            zres_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            i_q      <= i_d;
            n_q      <= n_d;
            mode_q   <= mode_d;
            int_en_q <= int_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            xres_q   <= xres_d;
            yres_q   <= yres_d;
            zres_q   <= zres_d;
            irq_q    <= irq_d;
        end
    end

    // Status word: only BUSY/DONE/OVF are ever driven high; START reads 0.
    always_comb begin
        controlRegisterOutput    = '0;
        controlRegisterOutput[3] = busy_q;
        controlRegisterOutput[4] = done_q;
        controlRegisterOutput[5] = ovf_q;
    end

    assign controlRegisterMask = p_WIDTH'(32'h39);
    assign lutAddress          = i_q;
    assign xResult             = xres_q;
    assign yResult             = yres_q;
    assign zResult             = zres_q;
    assign interrupt           = irq_q;

endmodule

// File: tb/tb_cordic_iterative_core.sv
// Bench for cordic_iterative_core: directed timing/boundary steps plus
// randomized runs checked against a plain-arithmetic CORDIC model.
module tb_cordic_iterative_core;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
    localparam bit GAINC = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam bit GAINC = 1'b0;
`endif
    localparam longint GAIN = 64'sh4DBA76D4;
    localparam real    PI   = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] xIn = '0, yIn = '0, zIn = '0, ctrlIn = '0;
    logic [31:0] angle;
    logic [4:0]  lutAddress;
    logic [31:0] xResult, yResult, zResult, ctrlOut, ctrlMask;
    logic        interrupt;

    int lut[32];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign angle = lut[lutAddress];

    cordic_iterative_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .xInput               (xIn),
        .yInput               (yIn),
        .zInput               (zIn),
        .controlRegisterInput (ctrlIn),
        .angle                (angle),
        .lutAddress           (lutAddress),
        .xResult              (xResult),
        .yResult              (yResult),
        .zResult              (zResult),
        .controlRegisterOutput(ctrlOut),
        .controlRegisterMask  (ctrlMask),
        .interrupt            (interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input longint exp, input longint tol);
        longint d;
        tests++;
        d = longint'($signed(obs)) - exp;
        assert (d >= -tol && d <= tol) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, $signed(obs), exp, tol);
        end
    endtask

    // Reference: textbook CORDIC on wide integers, wrap to 32 bits each step.
    function automatic void model(input int x0, input int y0, input int z0, input bit mode,
                                  input int n, output int xr, output int yr, output int zr,
                                  output bit ovf);
        int     x, y, z;
        longint xn, yn;
        bit     d;
        x = x0; y = y0; z = z0; ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = mode ? (y < 0) : (z >= 0);
            if (d) begin
                xn = longint'(x) - longint'(y >>> i);
                yn = longint'(y) + longint'(x >>> i);
                z  = z - lut[i];
            end else begin
                xn = longint'(x) + longint'(y >>> i);
                yn = longint'(y) - longint'(x >>> i);
                z  = z + lut[i];
            end
            if (xn != longint'(int'(xn)) || yn != longint'(int'(yn))) ovf = 1'b1;
            x = int'(xn);
            y = int'(yn);
        end
        if (GAINC) begin
            x = int'((longint'(x) * GAIN) >>> 31);
            y = int'((longint'(y) * GAIN) >>> 31);
        end
        xr = x; yr = y; zr = z;
    endfunction

    function automatic logic [31:0] ctrl_word(input int iter, input bit ien, input bit mode);
        return ((32'(iter) & 32'h1F) << 8) | (32'(ien) << 2) | (32'(mode) << 1) | 32'h1;
    endfunction

    // One complete run: start, optional input scrambling, result checks.
    task automatic run(input int x0, input int y0, input int z0, input bit mode,
                       input bit ien, input int iter, input bit scramble);
        int n, lat, xr, yr, zr;
        bit ov;
        n   = (iter == 0) ? 32 : iter;
        lat = n + 1 + EXTRA;
        model(x0, y0, z0, mode, n, xr, yr, zr, ov);
        @(negedge clk);
        xIn = x0; yIn = y0; zIn = z0;
        ctrlIn = ctrl_word(iter, ien, mode);
        @(negedge clk);
        ctrlIn = '0;
        check("run_status_busy", ctrlOut, 32'h08);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (scramble) begin
                xIn = $urandom(); yIn = $urandom(); zIn = $urandom();
                ctrlIn = $urandom() & 32'hFFFF_FFFE;
            end
        end
        check("run_pre_done_irq", {31'd0, interrupt}, 32'd0);
        @(negedge clk);
        check("run_x", xResult, xr);
        check("run_y", yResult, yr);
        check("run_z", zResult, zr);
        check("run_status_done", ctrlOut, 32'h10 | (32'(ov) << 5));
        check("run_irq", {31'd0, interrupt}, {31'd0, ien});
        @(negedge clk);
        check("run_irq_pulse_end", {31'd0, interrupt}, 32'd0);
        ctrlIn = '0;
    endtask

    initial begin
        int  xr, yr, zr, n;
        bit  ov;
        real ginv;

        for (int i = 0; i < 32; i++)
            lut[i] = int'($atan(1.0 / (2.0 ** i)) * 2147483648.0 / PI);
        ginv = 1.0;
        for (int i = 0; i < 32; i++) ginv = ginv * $sqrt(1.0 + 1.0 / (4.0 ** i));

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", xResult, 32'd0);
        check("rst_y", yResult, 32'd0);
        check("rst_z", zResult, 32'd0);
        check("rst_lut", {27'd0, lutAddress}, 32'd0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);
        check("rst_ctrl", ctrlOut, 32'd0);
        check("rst_mask", ctrlMask, 32'h39);
        rst = 1'b0;

        // Timing: ITER=4, rotation, interrupt enabled
        model(1000, 2000, 300, 1'b0, 4, xr, yr, zr, ov);
        @(negedge clk);
        xIn = 1000; yIn = 2000; zIn = 300;
        ctrlIn = ctrl_word(4, 1'b1, 1'b0);
        @(negedge clk);
        ctrlIn = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check("tim_lut", {27'd0, lutAddress}, 32'(k));
            check("tim_busy", ctrlOut, 32'h08);
            check("tim_mask", ctrlMask, 32'h39);
        end
        @(negedge clk);
        check("tim_busy_last", ctrlOut, 32'h08);
        check("tim_no_irq_yet", {31'd0, interrupt}, 32'd0);
        repeat (EXTRA) @(negedge clk);
        @(negedge clk);
        check("tim_done", ctrlOut, 32'h10);
        check("tim_irq", {31'd0, interrupt}, 32'd1);
        check("tim_x", xResult, xr);
        check("tim_y", yResult, yr);
        check("tim_z", zResult, zr);
        @(negedge clk);
        check("tim_irq_once", {31'd0, interrupt}, 32'd0);
        check("tim_done_sticky", ctrlOut, 32'h10);
        check("tim_mask_end", ctrlMask, 32'h39);

        // Rotation by 0 with full 32 iterations
        run(32'sd1073741824, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        check_near("rot_x", xResult, GAINC ? 64'sd1073741824 : 64'sd1768195409, 64);
        check_near("rot_y", yResult, 0, 64);
        check_near("rot_z", zResult, 0, 64);

        // Vectoring of (2^29, 2^29): angle pi/4 = 2^29 in LUT units
        run(32'sd536870912, 32'sd536870912, 0, 1'b1, 1'b1, 0, 1'b0);
        check_near("vec_y", yResult, 0, 64);
        check_near("vec_z", zResult, 64'sd536870912, 64);
        check_near("vec_x", xResult,
                   GAINC ? 64'sd759250125 : longint'(759250125.0 * ginv), 128);

        // START during busy is ignored
        model(123456, -654321, 1000000, 1'b0, 8, xr, yr, zr, ov);
        @(negedge clk);
        xIn = 123456; yIn = -654321; zIn = 1000000;
        ctrlIn = ctrl_word(8, 1'b1, 1'b0);
        @(negedge clk);
        ctrlIn = '0;
        @(negedge clk);
        xIn = 77; yIn = 88; zIn = 99;
        ctrlIn = ctrl_word(3, 1'b0, 1'b1);
        @(negedge clk);
        ctrlIn = '0;
        repeat (8 + 1 + EXTRA - 2) @(negedge clk);
        check("busy_start_irq", {31'd0, interrupt}, 32'd1);
        check("busy_start_x", xResult, xr);
        check("busy_start_y", yResult, yr);
        check("busy_start_z", zResult, zr);
        repeat (4) @(negedge clk);
        check("busy_start_idle", ctrlOut, 32'h10);
        check("busy_start_x_hold", xResult, xr);

        // Overflow is flagged, then cleared by the next START
        run(32'h70000000, 32'h70000000, 32'sd536870912, 1'b0, 1'b0, 0, 1'b0);
        check("ovf_set", {31'd0, ctrlOut[5]}, 32'd1);
        run(5000, -7000, 12345, 1'b0, 1'b1, 6, 1'b1);
        check("ovf_cleared", {31'd0, ctrlOut[5]}, 32'd0);

        // Reset in the middle of an ITER=8 run
        @(negedge clk);
        xIn = 400000; yIn = 300000; zIn = 2000;
        ctrlIn = ctrl_word(8, 1'b1, 1'b0);
        @(negedge clk);
        ctrlIn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_x", xResult, 32'd0);
        check("mid_rst_y", yResult, 32'd0);
        check("mid_rst_z", zResult, 32'd0);
        check("mid_rst_lut", {27'd0, lutAddress}, 32'd0);
        check("mid_rst_ctrl", ctrlOut, 32'd0);
        check("mid_rst_irq", {31'd0, interrupt}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (interrupt || ctrlOut != 32'd0) n++;
        end
        check("mid_rst_stays_idle", 32'(n), 32'd0);
        run(400000, 300000, 2000, 1'b0, 1'b1, 8, 1'b0);

        // Randomized runs against the model
        for (int r = 0; r < 10; r++) begin
            run(int'($urandom()), int'($urandom()), int'($urandom()), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
